// File: rtl/cla_pkg.sv
// Shared types and elaboration-time parameter check for the pipelined lookahead adder.
package cla_pkg;

  typedef struct packed {
    logic cout;
    logic ovf;
    logic zero;
  } flags_t;

  function automatic bit params_ok(input int width, input int block);
    return (block >= 1) && (width >= block) &&
           ((width % ((block >= 1) ? block : 1)) == 0);
  endfunction

endpackage

// File: rtl/cla_group.sv
// Combinational BLOCK-bit carry-lookahead group: every carry is a flat sum of products of p/g/cin.
// Also exports group propagate/generate so groups can later be combined in a second lookahead level.
module cla_group
  import cla_pkg::*;
#(
  parameter int BLOCK = 8
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             cin,
  output logic [BLOCK-1:0] sum,
  output logic             cout,
  output logic             grp_p,
  output logic             grp_g
);

  logic [BLOCK-1:0] p;
  logic [BLOCK-1:0] g;
  logic [BLOCK:0]   c;
  logic             term;

  assign p = a ^ b;
  assign g = a & b;

  // c[i] = cin&p[0..i-1] | OR_j g[j]&p[j+1..i-1]; loops unroll to two-level logic, no ripple
  always_comb begin
    c     = '0;
    term  = 1'b0;
    grp_g = 1'b0;
    for (int i = 0; i <= BLOCK; i++) begin
      term = cin;
      for (int m = 0; m < i; m++) term = term & p[m];
      c[i] = term;
      for (int j = 0; j < i; j++) begin
        term = g[j];
        for (int m = j + 1; m < i; m++) term = term & p[m];
        c[i] = c[i] | term;
      end
    end
    for (int j = 0; j < BLOCK; j++) begin
      term = g[j];
      for (int m = j + 1; m < BLOCK; m++) term = term & p[m];
      grp_g = grp_g | term;
    end
  end

  assign grp_p = &p;
  assign sum   = p ^ c[BLOCK-1:0];
  assign cout  = c[BLOCK];

endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined lookahead add/sub, one BLOCK group per stage; STAGES cycles latency, 1 beat/clk.
// A held result (out_valid && !out_ready) freezes every stage; in_ready is that stall's inverse.
module cla_pipe_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int BLOCK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero
);

  localparam int STAGES = WIDTH / BLOCK;

  if (!params_ok(WIDTH, BLOCK)) begin : g_param_err
    $error("cla_pipe_adder: WIDTH must be a positive multiple of BLOCK");
  end

  logic              adv;
  logic [WIDTH-1:0]  b_eff;
  logic              c0;
  logic [STAGES-1:0] vld_q;
  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [WIDTH-1:0]  s_q [STAGES];
  logic              c_q [STAGES];
  logic [WIDTH-1:0]  a_n [STAGES];
  logic [WIDTH-1:0]  b_n [STAGES];
  logic [WIDTH-1:0]  s_n [STAGES];
  logic              c_n [STAGES];
  logic              c_msb;
  flags_t            flg_n;
  flags_t            flg_q;

  assign b_eff    = in_sub ? ~in_b : in_b;
  assign c0       = in_sub | in_cin;
  assign adv      = ~vld_q[STAGES-1] | out_ready;
  assign in_ready = adv;

  // Operands travel whole; each stage replaces only its own group in the running sum word
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic [WIDTH-1:0] s_i;
    logic [WIDTH-1:0] s_o;
    logic             c_i;
    logic [BLOCK-1:0] gs;
    logic             gc;
    logic             gp;
    logic             gg;

    if (k == 0) begin : g_head
      assign a_i = in_a;
      assign b_i = b_eff;
      assign s_i = '0;
      assign c_i = c0;
    end else begin : g_body
      assign a_i = a_q[k-1];
      assign b_i = b_q[k-1];
      assign s_i = s_q[k-1];
      assign c_i = c_q[k-1];
    end

    cla_group #(.BLOCK(BLOCK)) u_grp (
      .a     (a_i[k*BLOCK +: BLOCK]),
      .b     (b_i[k*BLOCK +: BLOCK]),
      .cin   (c_i),
      .sum   (gs),
      .cout  (gc),
      .grp_p (gp),
      .grp_g (gg)
    );

    always_comb begin
      s_o = s_i;
      s_o[k*BLOCK +: BLOCK] = gs;
      assert (gc == (gg | (gp & c_i)));
    end

    assign a_n[k] = a_i;
    assign b_n[k] = b_i;
    assign s_n[k] = s_o;
    assign c_n[k] = gc;
  end

  // Carry into the MSB recovered from the MSB sum bit and its (effective) operand bits
  assign c_msb = s_n[STAGES-1][WIDTH-1] ^ a_n[STAGES-1][WIDTH-1] ^ b_n[STAGES-1][WIDTH-1];

  always_comb begin
    flg_n      = '0;
    flg_n.cout = c_n[STAGES-1];
    flg_n.ovf  = c_msb ^ c_n[STAGES-1];
    flg_n.zero = ~|s_n[STAGES-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      flg_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
        c_q[k] <= 1'b0;
      end
    end else if (adv) begin
      vld_q[0] <= in_valid;
      for (int k = 1; k < STAGES; k++) vld_q[k] <= vld_q[k-1];
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= a_n[k];
        b_q[k] <= b_n[k];
        s_q[k] <= s_n[k];
        c_q[k] <= c_n[k];
      end
      flg_q <= flg_n;
    end
  end

  assign out_valid = vld_q[STAGES-1];
  assign out_sum   = s_q[STAGES-1];
  assign out_cout  = flg_q.cout;
  assign out_ovf   = flg_q.ovf;
  assign out_zero  = flg_q.zero;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Scoreboard bench for cla_pipe_adder: arithmetic reference model, decoupled driver and monitor.
module tb_cla_pipe_adder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        in_cin;
  logic        in_sub;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_sum;
  logic        out_cout;
  logic        out_ovf;
  logic        out_zero;

  cla_pipe_adder #(.WIDTH(32), .BLOCK(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf),
    .out_zero  (out_zero)
  );

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
    int          cyc;
    int          stl;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc      = 0;
  int          stall_cnt = 0;
  bit          rand_ready = 0;
  bit          held = 0;
  logic [35:0] held_dat;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
  endtask

  // Reference: plain integer arithmetic on the operands, signed range test for overflow
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic cin, input logic sub);
    exp_t   e;
    longint sa, sb, r;
    longint ua, ub, ur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'h0, a});
    ub = longint'({32'h0, b});
    if (sub) begin
      r      = sa - sb;
      ur     = ua - ub;
      e.cout = (ua >= ub);
    end else begin
      r      = sa + sb + longint'(cin);
      ur     = ua + ub + longint'(cin);
      e.cout = (ur >= 64'sd4294967296);
    end
    e.sum  = ur[31:0];
    e.ovf  = (r > 64'sd2147483647) || (r < -64'sd2147483648);
    e.zero = (e.sum == 32'h0);
    e.cyc  = 0;
    e.stl  = 0;
    return e;
  endfunction

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic cin, input logic sub);
    exp_t e;
    int   guard;
    guard = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    in_cin = cin;
    in_sub = sub;
    #1;
    while (!in_ready && guard < 1000) begin
      guard++;
      @(negedge clk);
      #1;
    end
    if (!in_ready) begin
      check("in_ready_timeout", 64'(in_ready), 64'd1);
    end else begin
      e     = model(a, b, cin, sub);
      e.cyc = cyc;
      e.stl = stall_cnt;
      exp_q.push_back(e);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    check("drain_remaining", 64'(exp_q.size()), 64'd0);
  endtask

  function automatic logic [31:0] rnd_op();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    out_ready = 1'b1;
    forever begin
      @(negedge clk);
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: samples 2 time units after the falling edge, when all bench inputs have settled
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        held = 0;
      end else begin
        check("in_ready_rule", 64'(in_ready), 64'(!out_valid || out_ready));
        if (held)
          check("held_stable", 64'({out_valid, out_sum, out_cout, out_ovf, out_zero}), 64'(held_dat));
        held     = out_valid && !out_ready;
        held_dat = {out_valid, out_sum, out_cout, out_ovf, out_zero};
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_beat", 64'(out_sum), 64'hDEAD_0000_0000);
          end else begin
            e = exp_q.pop_front();
            check("sum",     64'(out_sum),  64'(e.sum));
            check("cout",    64'(out_cout), 64'(e.cout));
            check("ovf",     64'(out_ovf),  64'(e.ovf));
            check("zero",    64'(out_zero), 64'(e.zero));
            check("latency", 64'(cyc - e.cyc), 64'(4 + stall_cnt - e.stl));
          end
        end
        if (out_valid && !out_ready) stall_cnt++;
      end
      cyc++;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    in_cin = 1'b0;
    in_sub = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_sum",   64'(out_sum),   64'd0);
    check("rst_out_flags", 64'({out_cout, out_ovf, out_zero}), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("in_ready_after_rst", 64'(in_ready), 64'd1);

    send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    idle();
    drain();
    send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    send(32'h1234_5678, 32'h0FED_CBA8, 1'b1, 1'b0);
    send(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1);
    send(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1);
    send(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1);
    send(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0);
    idle();
    drain();

    for (int i = 0; i < 100; i++)
      send(rnd_op(), rnd_op(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    idle();
    drain();

    rand_ready = 1;
    for (int i = 0; i < 100; i++)
      send(rnd_op(), rnd_op(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    idle();
    drain();
    rand_ready = 0;

    // Reset with three beats in flight, the oldest already presented at the output
    for (int i = 0; i < 3; i++) send(32'($urandom), 32'($urandom), 1'b0, 1'b0);
    idle();
    @(negedge clk);
    #1;
    check("pre_rst_out_valid", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_out_sum",   64'(out_sum),   64'd0);
    check("mid_rst_flags",     64'({out_cout, out_ovf, out_zero}), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      #1;
      check("no_stale_beat", 64'(out_valid), 64'd0);
    end
    send(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
    idle();
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
